// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state and the memory responder FSM state.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2,
    RESP   = 2'd3
  } rsp_state_t;
endpackage

// File: rtl/iline_buffer.sv
// One-entry instruction buffer: tag/data/valid with fill, address invalidate,
// flush and a combinational hit on the lookup address.
module iline_buffer
  import cpu_types_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  fill,
  input  word_t fill_addr,
  input  word_t fill_data,
  input  logic  fill_valid,
  input  logic  inval,
  input  word_t inval_addr,
  input  logic  flush,
  input  word_t lookup_addr,
  output logic  hit,
  output word_t hit_data
);
  word_t tag_q, data_q;
  logic  valid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (fill) begin
        tag_q  <= fill_addr;
        data_q <= fill_data;
      end
      // flush wins over a same-cycle fill so a halted core never sees stale lines
      if (flush)
        valid_q <= 1'b0;
      else if (fill)
        valid_q <= fill_valid;
      else if (inval && (inval_addr == tag_q))
        valid_q <= 1'b0;
    end
  end

  assign hit      = EN && valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;
endmodule

// File: rtl/dp_mem_responder.sv
// Memory-side responder: arbitrates fetch/load/store onto one RAM port (data first),
// waits out RAM latency and returns one-cycle ihit/dhit pulses.
module dp_mem_responder
  import cpu_types_pkg::*;
#(
  parameter word_t ERR_WORD = 32'hBAD1BAD1,
  parameter bit    IBUF_EN  = 1'b1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      halt,
  input  logic      imemREN,
  input  word_t     imemaddr,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      ihit,
  output word_t     imemload,
  output logic      dhit,
  output word_t     dmemload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);
  rsp_state_t state, nxt;
  word_t      addr_q, sdata_q, load_q;
  logic       is_store_q, is_ifetch_q, err_q;

  logic  dreq, ireq, ram_done, ram_err, buf_hit;
  word_t buf_data;

  assign dreq     = dmemREN | dmemWEN;
  assign ireq     = imemREN & ~halt;
  assign ram_err  = (ramstate == ERROR);
  assign ram_done = (ramstate == ACCESS) | ram_err;

  iline_buffer #(.EN(IBUF_EN)) u_ibuf (
    .CLK        (CLK),
    .RST        (RST),
    .fill       ((state == IFETCH) && ram_done),
    .fill_addr  (addr_q),
    .fill_data  (ram_err ? ERR_WORD : ramload),
    .fill_valid (~ram_err),
    .inval      ((state == DACC) && ram_done && is_store_q),
    .inval_addr (addr_q),
    .flush      (halt),
    .lookup_addr(imemaddr),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      load_q      <= '0;
      is_store_q  <= 1'b0;
      is_ifetch_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (dreq) begin
            // load+store together is served as a store
            addr_q      <= dmemaddr;
            sdata_q     <= dmemWEN ? dmemstore : '0;
            is_store_q  <= dmemWEN;
            is_ifetch_q <= 1'b0;
          end else if (ireq) begin
            addr_q      <= imemaddr;
            is_store_q  <= 1'b0;
            is_ifetch_q <= 1'b1;
            if (buf_hit) load_q <= buf_data;
          end
        end
        DACC, IFETCH: begin
          if (ram_done) begin
            if (is_store_q)   load_q <= '0;
            else if (ram_err) load_q <= ERR_WORD;
            else              load_q <= ramload;
            if (ram_err) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (dreq)                 nxt = DACC;
        else if (ireq && buf_hit) nxt = RESP;
        else if (ireq)            nxt = IFETCH;
      end
      DACC, IFETCH: if (ram_done) nxt = RESP;
      RESP:                       nxt = IDLE;
      default:                    nxt = IDLE;
    endcase
  end

  always_comb begin
    ihit     = (state == RESP) &&  is_ifetch_q;
    dhit     = (state == RESP) && !is_ifetch_q;
    imemload = ihit ? load_q : '0;
    dmemload = dhit ? load_q : '0;
    ramREN   = (state == IFETCH) || ((state == DACC) && !is_store_q);
    ramWEN   = (state == DACC) && is_store_q;
    ramaddr  = (state == IFETCH || state == DACC) ? addr_q : '0;
    ramstore = ramWEN ? sdata_q : '0;
    err      = err_q;
  end
endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for `datapath_cache_if`: serves the datapath's instruction-fetch and data load/store requests from a single shared RAM port, returning `ihit`/`dhit` pulses with `imemload`/`dmemload`. It sits between the datapath and the RAM model. It arbitrates with data priority, waits out RAM latency, and holds a one-entry instruction buffer so a repeated fetch of the same PC skips the RAM.

## Interface
Parameters:
- `ERR_WORD`, default 32'hBAD1BAD1: load data returned when the RAM reports ERROR.
- `IBUF_EN`, default 1: enables the instruction buffer. When 0, every fetch goes to RAM.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous reset, active-high.
- `halt` in 1: datapath halt. While high, fetches are not served.
- `imemREN` in 1: fetch request.
- `imemaddr` in 32: fetch address, word aligned.
- `dmemREN` in 1: load request.
- `dmemWEN` in 1: store request.
- `dmemaddr` in 32: data address, word aligned.
- `dmemstore` in 32: store data.
- `ihit` out 1: one-cycle fetch-complete pulse.
- `imemload` out 32: fetched instruction, valid while `ihit`=1.
- `dhit` out 1: one-cycle data-complete pulse.
- `dmemload` out 32: load data, valid while `dhit`=1.
- `ramREN` out 1: RAM read request.
- `ramWEN` out 1: RAM write request.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data, valid when `ramstate`=ACCESS.
- `ramstate` in 2 (`ramstate_t`): FREE, BUSY, ACCESS or ERROR.
- `err` out 1: sticky; set by any ERROR completion, cleared only by reset.

## Operation
State machine `rsp_state_t`: IDLE, IFETCH, DACC, RESP.
- **IDLE** (priority order):
  - `dmemREN|dmemWEN` → DACC. Latch the address; for stores also latch the data.
  - else `imemREN & !halt` with buffer valid and tag == `imemaddr` (and `IBUF_EN`) → RESP with ihit pending and load = buffer data. No RAM access.
  - else `imemREN & !halt` → IFETCH, latch `imemaddr`.
  - `dmemREN & dmemWEN` both high: treated as a store.
- **DACC**:
  - Drive `ramREN` (load) or `ramWEN` (store) with the latched address/data every cycle until `ramstate` is ACCESS or ERROR.
  - Then → RESP with dhit pending.
  - Capture `ramload`, or `ERR_WORD` on ERROR; `dmemload` is 0 for a store.
- **IFETCH**:
  - Same as DACC, with `ramREN` only.
  - On completion, write buffer tag = address, data = word, valid = 1 (ERROR completion leaves valid = 0).
  - Then → RESP with ihit pending.
- **RESP**: assert the pending `ihit` or `dhit` for exactly one cycle with the registered load word. Requests are ignored. → IDLE.

Buffer coherence:
- A store completing to an address equal to the buffer tag clears valid.
- `halt` high clears valid.

RAM outputs are 0 outside DACC/IFETCH. `ramstate` FREE/BUSY means keep holding.

## Timing
- Reset values: state IDLE, buffer valid 0, tag/data 0, `err` 0, every output 0.
- Buffer hit: request sampled in IDLE at edge N, `ihit` high during cycle N+1. Latency 1 cycle.
- RAM access with k BUSY cycles: issued during cycle N+1, ACCESS during cycle N+1+k, hit during cycle N+2+k. Minimum 2 cycles.
- One request is in flight at a time. After RESP, at least one IDLE cycle passes before the next issue, so the datapath sees the pulse and can update its request lines.
- A request that changes or drops while DACC/IFETCH is waiting does not abort the access. The latched values are used and the pulse is still produced.
- Reset asserted mid-access: next edge returns to IDLE, RAM requests drop, and no hit is produced.
- The data request wins if both requests are present in IDLE; the fetch waits.
- A store completing in the same cycle `halt` rises: the invalidate applies; no conflict.

## Structure
- Add `rsp_state_t` to `cpu_types_pkg`. `ramstate_t` and `word_t` already live there.
- `ERR_WORD` stays a parameter.
- One sub-module, `iline_buffer`: tag/data/valid register with a fill port, an invalidate-on-address port, a flush port and a combinational hit output.
- The FSM and RAM muxing stay in the top.

## Test plan
- **Load, 2 BUSY cycles:** `dmemREN`=1, addr 0x40; RAM gives BUSY, BUSY, ACCESS with `ramload`=0xDEADBEEF. Expect `ramREN` held with `ramaddr`=0x40 for 3 cycles, then `dhit`=1 for one cycle with `dmemload`=0xDEADBEEF.
- **Fetch then refetch:** fetch 0x0 from RAM (0x8C010004), then refetch 0x0. Expect no `ramREN` on the second fetch and `ihit` one cycle after the request, with 0x8C010004.
- **Store invalidates buffer:** store 0x12345678 to 0x0 after the buffer is filled, then fetch 0x0. Expect `ramWEN` with the store data, then `ramREN` issued for the fetch (buffer miss).
- **Simultaneous requests and halt:** `imemREN`=1 and `dmemREN`=1 together → data access first, then fetch. With `halt`=1 and `imemREN`=1 → no `ihit`, no RAM activity.
- **ERROR completion:** `ramstate`=ERROR on a load → `dhit` with `dmemload`=0xBAD1BAD1, and `err` stays 1 until reset.
- **Reset mid-access:** `RST` pulsed during BUSY → the next cycle has all outputs 0, state IDLE, and no hit.
